rotate_seq_ctrl: RTL and testbench
==================================

Name: rotate_seq_ctrl

Overview:
Command sequencer that drives the ctrl/data inputs of a univ_rotate_reg (DW-bit universal rotate register).
- Accepts one rotate command at a time over a valid/ready handshake: optional load value, direction, rotate amount.
- Issues the cycle-by-cycle ctrl sequence: load, N single-step rotates, then hold.
- Pulses done when the register content is final. Sits between a requester and a single rotate register instance.

Parameters:
DW, 4, data width of the controlled register; power of two, >= 2
AW, $clog2(DW), width of the rotate-amount field
SHORTEST, 1, 1 = rotate via the shorter direction; 0 = always the requested direction

Ports:
clk  input  1  system clock, rising edge
async_rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_load  input  1  1 = load cmd_data before rotating; 0 = rotate current content
cmd_dir  input  1  0 = rotate left (toward MSB), 1 = rotate right
cmd_amt  input  AW  rotate amount, 0..DW-1
cmd_data  input  DW  value to load
reg_ctrl  output  2  to register ctrl: 00 load, 10 rotate left, 01 rotate right, 11 hold
reg_data  output  DW  to register data input
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle pulse, command complete

Behaviour:
- Reset: async_rst high forces state IDLE immediately, without waiting for a clock edge.
- Reset output values: reg_ctrl=11, reg_data=0, busy=0, done=0, cmd_ready=1. All captured command fields clear to 0.
- Outputs are driven from registered state; there is no combinational path from cmd_* to reg_ctrl or reg_data.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_load, cmd_dir, cmd_amt and cmd_data are captured at that edge. cmd_valid while busy is ignored and the requester holds it.
- Step computation at acceptance, eff = cmd_amt:
  - If SHORTEST=1 and eff > DW/2: dir_eff = ~cmd_dir, steps = DW - eff.
  - Otherwise: dir_eff = cmd_dir, steps = eff.
  - Tie eff == DW/2 keeps the requested direction.
  - steps is held in an AW-bit down-counter.
- States: IDLE, LOAD, ROT, DONE.
  - IDLE: reg_ctrl=11, cmd_ready=1. On accept: go to LOAD if cmd_load=1; else ROT if steps>0; else DONE.
  - LOAD, one cycle: reg_ctrl=00, reg_data=captured data. Next: ROT if steps>0, else DONE.
  - ROT: reg_ctrl=10 if dir_eff=0, 01 if dir_eff=1. Counter decrements each cycle; exactly `steps` cycles in ROT, then DONE.
  - DONE, one cycle: reg_ctrl=11, done=1. Next: IDLE.
- reg_data holds the last captured data in all states; it is only meaningful in LOAD.
- Latency from accept edge to done-high cycle: cmd_load + steps + 1 cycles. Worst case DW/2 + 2 with SHORTEST=1, DW + 1 with SHORTEST=0.
- Back-to-back: cmd_ready returns in the IDLE cycle after DONE. Minimum one IDLE cycle between commands.
- Assertion of async_rst in any state aborts the command immediately. The register content is then left as is; no hold or cleanup cycle is issued.
- busy = 1 in LOAD, ROT and DONE.

Test Plan:
All scenarios use DW=4 with a univ_rotate_reg instance (sync_rst tied low after init) on reg_ctrl/reg_data, and check its q.
1. Assert async_rst mid-cycle between edges -> reg_ctrl=11, busy=0, done=0, cmd_ready=1 immediately; outputs stay there until release.
2. SHORTEST=1, cmd_load=1, data=4'b1001, dir=0, amt=1 -> reg_ctrl sequence 00,10,11 with done in the 3rd cycle after accept; q=4'b0011.
3. SHORTEST=1, cmd_load=1, data=4'b1001, dir=0, amt=3 -> sequence 00,01,11 (one right rotate); q=4'b1100. Repeat with SHORTEST=0 -> 00,10,10,10,11; same q=4'b1100.
4. cmd_load=0, amt=0 on q=4'b0110 -> DONE the cycle after accept, reg_ctrl=11 throughout, q stays 4'b0110. Then cmd_load=0, dir=1, amt=2 -> 01,01,11; q=4'b1001.
5. cmd_valid held high for two commands -> second not accepted while busy=1; it is accepted in the first IDLE cycle after the done pulse, and cmd_ready is low in exactly the busy cycles.
6. Assert async_rst during ROT of an amt=2 left command (after 1 step) -> reg_ctrl=11 without a clock edge, no done pulse; q keeps the partially rotated value (one step done).

Source files
------------

// File: rtl/rotate_seq_ctrl.sv
// Command sequencer for a universal rotate register: takes one command at a time and plays out
// load / N rotate / hold on reg_ctrl, then pulses done.
module rotate_seq_ctrl #(
  parameter int unsigned DW       = 4,
  parameter int unsigned AW       = $clog2(DW),
  parameter bit          SHORTEST = 1'b1
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_load,
  input  logic          cmd_dir,
  input  logic [AW-1:0] cmd_amt,
  input  logic [DW-1:0] cmd_data,
  output logic [1:0]    reg_ctrl,
  output logic [DW-1:0] reg_data,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ROT  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [AW:0] DW_W   = (AW+1)'(DW);
  localparam logic [AW:0] HALF_W = (AW+1)'(DW / 2);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] data_q, data_d;

  logic          accept;
  logic [AW:0]   eff_ext;
  logic [AW:0]   short_steps;
  logic          dir_acc;
  logic [AW-1:0] steps_acc;

  assign accept      = cmd_valid && cmd_ready;
  assign eff_ext     = {1'b0, cmd_amt};
  assign short_steps = DW_W - eff_ext;

  // Amounts past half a turn go the other way round; a tie keeps the requested direction.
  always_comb begin
    dir_acc   = cmd_dir;
    steps_acc = cmd_amt;
    if (SHORTEST && (eff_ext > HALF_W)) begin
      dir_acc   = ~cmd_dir;
      steps_acc = short_steps[AW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d = cmd_data;
          dir_d  = dir_acc;
          cnt_d  = steps_acc;
          if (cmd_load) begin
            state_d = LOAD;
          end else if (steps_acc != '0) begin
            state_d = ROT;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: state_d = (cnt_q != '0) ? ROT : DONE;
      ROT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == AW'(1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    reg_ctrl = 2'b11;
    unique case (state_q)
      LOAD:    reg_ctrl = 2'b00;
      ROT:     reg_ctrl = dir_q ? 2'b01 : 2'b10;
      default: reg_ctrl = 2'b11;
    endcase
  end

  assign reg_data  = data_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Bench for rotate_seq_ctrl: two instances (shortest-path and fixed-direction) each driving a
// behavioural rotate register, checked with vector tables, corner sequences and random commands.
module tb_rotate_seq_ctrl;

  logic       clk;
  logic       async_rst;
  logic       valid_s, valid_l;
  logic       cmd_load, cmd_dir;
  logic [1:0] cmd_amt;
  logic [3:0] cmd_data;

  logic       ready_s, busy_s, done_s, ready_l, busy_l, done_l;
  logic [1:0] ctrl_s, ctrl_l;
  logic [3:0] data_s, data_l;
  logic [3:0] q_s, q_l;

  int checks = 0;
  int errors = 0;

  rotate_seq_ctrl #(.DW(4), .AW(2), .SHORTEST(1'b1)) u_dut_s (
    .clk(clk), .async_rst(async_rst), .cmd_valid(valid_s), .cmd_ready(ready_s),
    .cmd_load(cmd_load), .cmd_dir(cmd_dir), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .reg_ctrl(ctrl_s), .reg_data(data_s), .busy(busy_s), .done(done_s)
  );

  rotate_seq_ctrl #(.DW(4), .AW(2), .SHORTEST(1'b0)) u_dut_l (
    .clk(clk), .async_rst(async_rst), .cmd_valid(valid_l), .cmd_ready(ready_l),
    .cmd_load(cmd_load), .cmd_dir(cmd_dir), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .reg_ctrl(ctrl_l), .reg_data(data_l), .busy(busy_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural universal rotate register on each instance's outputs.
  function automatic logic [3:0] reg_next(input logic [3:0] q, input logic [1:0] c,
                                          input logic [3:0] d);
    case (c)
      2'b00:   return d;
      2'b10:   return {q[2:0], q[3]};
      2'b01:   return {q[0], q[3:1]};
      default: return q;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    q_s <= reg_next(q_s, ctrl_s, data_s);
    q_l <= reg_next(q_l, ctrl_l, data_l);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issues one command and records the reg_ctrl trace from the cycle after accept to done.
  task automatic run_cmd(input bit lng, input bit ld, input bit dr, input logic [1:0] amt,
                         input logic [3:0] dat, output int lat, output logic [15:0] trace,
                         output int rots, output logic [3:0] qv);
    int   n;
    logic [1:0] c;
    bit   found;
    lat = -1; trace = '0; rots = 0; qv = 'x; found = 0;
    @(negedge clk);
    cmd_load = ld; cmd_dir = dr; cmd_amt = amt; cmd_data = dat;
    if (lng) valid_l = 1'b1; else valid_s = 1'b1;
    n = 0;
    while (!(lng ? ready_l : ready_s) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      check("accept_timeout", 32'(n), 32'd0);
      valid_s = 1'b0; valid_l = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    valid_s = 1'b0; valid_l = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      c = lng ? ctrl_l : ctrl_s;
      trace = {trace[13:0], c};
      if (c == 2'b10 || c == 2'b01) rots++;
      if (lng ? done_l : done_s) begin
        lat = k;
        qv = lng ? q_l : q_s;
        found = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!found) check("done_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    bit          lng;
    bit          ld;
    bit          dr;
    logic [1:0]  amt;
    logic [3:0]  dat;
    int          len;
    logic [15:0] seq;
    logic [3:0]  q;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          lat, rots, acc_cnt, done_cnt, steps, left, v;
    int          acc_at[2], done_at[2], mq[2];
    logic [15:0] trace;
    logic [3:0]  qv;
    bit          lng, ld, dr;
    logic [1:0]  amt;
    logic [3:0]  dat;

    async_rst = 1'b0; valid_s = 1'b0; valid_l = 1'b0;
    cmd_load = 1'b0; cmd_dir = 1'b0; cmd_amt = '0; cmd_data = '0;

    // Reset asserted between edges takes effect at once and holds until release.
    @(posedge clk);
    #2 async_rst = 1'b1;
    #1;
    check("rst_ctrl", 32'(ctrl_s), 32'h3);
    check("rst_busy", 32'(busy_s), 32'h0);
    check("rst_done", 32'(done_s), 32'h0);
    check("rst_ready", 32'(ready_s), 32'h1);
    check("rst_data", 32'(data_s), 32'h0);
    check("rst_ready_l", 32'(ready_l), 32'h1);
    repeat (2) @(negedge clk);
    check("rst_hold_ctrl", 32'(ctrl_s), 32'h3);
    check("rst_hold_busy", 32'(busy_s), 32'h0);
    async_rst = 1'b0;

    vecs[0] = '{lng:0, ld:1, dr:0, amt:2'd1, dat:4'b1001, len:3, seq:16'b00_10_11, q:4'b0011};
    vecs[1] = '{lng:0, ld:1, dr:0, amt:2'd3, dat:4'b1001, len:3, seq:16'b00_01_11, q:4'b1100};
    vecs[2] = '{lng:1, ld:1, dr:0, amt:2'd3, dat:4'b1001, len:5, seq:16'b00_10_10_10_11,
                q:4'b1100};
    vecs[3] = '{lng:0, ld:1, dr:0, amt:2'd0, dat:4'b0110, len:2, seq:16'b00_11, q:4'b0110};
    vecs[4] = '{lng:0, ld:0, dr:0, amt:2'd0, dat:4'b0000, len:1, seq:16'b11, q:4'b0110};
    vecs[5] = '{lng:0, ld:0, dr:1, amt:2'd2, dat:4'b0000, len:3, seq:16'b01_01_11, q:4'b1001};
    vecs[6] = '{lng:0, ld:1, dr:1, amt:2'd2, dat:4'b0001, len:4, seq:16'b00_01_01_11,
                q:4'b0100};

    foreach (vecs[i]) begin
      run_cmd(vecs[i].lng, vecs[i].ld, vecs[i].dr, vecs[i].amt, vecs[i].dat,
              lat, trace, rots, qv);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].len));
      check($sformatf("vec%0d_ctrl_seq", i), 32'(trace), 32'(vecs[i].seq));
      check($sformatf("vec%0d_q", i), 32'(qv), 32'(vecs[i].q));
    end

    // Two commands with cmd_valid held high: second accepted only after done.
    acc_cnt = 0; done_cnt = 0; acc_at = '{-1, -1}; done_at = '{-1, -1};
    cmd_load = 1'b0; cmd_dir = 1'b0; cmd_amt = 2'd1; cmd_data = 4'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) valid_s = 1'b1;
      if (acc_cnt == 2) valid_s = 1'b0;
      check($sformatf("b2b_ready_vs_busy_c%0d", c), 32'(ready_s), 32'(!busy_s));
      if (ready_s && valid_s && acc_cnt < 2) begin
        acc_at[acc_cnt] = c;
        acc_cnt++;
      end
      if (done_s && done_cnt < 2) begin
        done_at[done_cnt] = c;
        done_cnt++;
      end
    end
    check("b2b_accepts", 32'(acc_cnt), 32'd2);
    check("b2b_second_accept", 32'(acc_at[1]), 32'd3);
    check("b2b_first_done", 32'(done_at[0]), 32'd2);
    check("b2b_second_done", 32'(done_at[1]), 32'd5);

    // Reset in the middle of a two-step left rotate, after the first step.
    @(negedge clk);
    cmd_load = 1'b1; cmd_dir = 1'b0; cmd_amt = 2'd2; cmd_data = 4'b0001; valid_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_s = 1'b0;
    check("abort_load_ctrl", 32'(ctrl_s), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 async_rst = 1'b1;
    #1;
    check("abort_ctrl", 32'(ctrl_s), 32'h3);
    check("abort_busy", 32'(busy_s), 32'h0);
    check("abort_ready", 32'(ready_s), 32'h1);
    check("abort_done", 32'(done_s), 32'h0);
    check("abort_q_partial", 32'(q_s), 32'b0010);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort_no_done_c%0d", c), 32'(done_s), 32'h0);
    end
    async_rst = 1'b0;
    @(negedge clk);
    check("abort_q_kept", 32'(q_s), 32'b0010);
    check("abort_idle_ctrl", 32'(ctrl_s), 32'h3);

    // Random commands against an arithmetic model of net rotation and latency.
    mq = '{0, 0};
    for (int i = 0; i < 40; i++) begin
      lng = i[0];
      ld  = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      amt = 2'($urandom_range(0, 3));
      dat = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(lng, ld, dr, amt, dat, lat, trace, rots, qv);
      steps = (!lng && int'(amt) > 2) ? 4 - int'(amt) : int'(amt);
      v     = ld ? int'(dat) : mq[lng];
      left  = dr ? (4 - int'(amt)) % 4 : int'(amt);
      mq[lng] = ((v << left) | (v >> (4 - left))) & 15;
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(int'(ld) + steps + 1));
      check($sformatf("rnd%0d_rot_cycles", i), 32'(rots), 32'(steps));
      check($sformatf("rnd%0d_q", i), 32'(qv), 32'(mq[lng]));
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
